// File: rtl/mipi_csi_header_parser.sv
// MIPI CSI-2 packet parser for the 4-lane, lane-aligned 32-bit word stream.
// Corrects headers with the 6-bit ECC, decodes sync short packets and forwards long-packet payload.
module mipi_csi_header_parser #(
  parameter logic [3:0] VC_ACCEPT = 4'b1111
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic        payload_valid_o,
  output logic [31:0] payload_o,
  output logic [3:0]  payload_be_o,
  output logic        payload_last_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic [1:0]  vc_o,
  output logic [5:0]  dt_o,
  output logic [15:0] word_count_o,
  output logic        ecc_corrected_o,
  output logic        ecc_error_o,
  output logic        truncated_o
);

  typedef enum logic [1:0] {
    ST_SKIP,
    ST_IDLE,
    ST_PAYLOAD,
    ST_DRAIN
  } state_e;

  // Header bits covered by each ECC parity bit; bit k of all six masks is the column of Dk.
  localparam logic [23:0] P0_MASK = 24'hF12CB7;
  localparam logic [23:0] P1_MASK = 24'hF2555B;
  localparam logic [23:0] P2_MASK = 24'h749A6D;
  localparam logic [23:0] P3_MASK = 24'hB8E38E;
  localparam logic [23:0] P4_MASK = 24'hDF03F0;
  localparam logic [23:0] P5_MASK = 24'hEFFC00;

  // ---------------------------------------------------------------------------
  // Header ECC: syndrome, single-bit correction, field extraction
  // ---------------------------------------------------------------------------
  logic [23:0] hdr_raw;
  logic [23:0] hdr_fix;
  logic [5:0]  parity;
  logic [5:0]  syndrome;
  logic        syn_col_hit;
  logic        syn_par_hit;
  logic        hdr_ok;
  logic        hdr_corr;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic        vc_ok;
  logic        unused_ecc_bits;

  assign hdr_raw         = data_i[23:0];
  assign unused_ecc_bits = ^data_i[31:30];

  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so evaluation order is sequential and no latch can be inferred.
  always_comb begin
    parity[0] = ^(hdr_raw & P0_MASK);
    parity[1] = ^(hdr_raw & P1_MASK);
    parity[2] = ^(hdr_raw & P2_MASK);
    parity[3] = ^(hdr_raw & P3_MASK);
    parity[4] = ^(hdr_raw & P4_MASK);
    parity[5] = ^(hdr_raw & P5_MASK);
    syndrome  = parity ^ data_i[29:24];

    hdr_fix     = hdr_raw;
    syn_col_hit = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (syndrome == {P5_MASK[k], P4_MASK[k], P3_MASK[k],
                       P2_MASK[k], P1_MASK[k], P0_MASK[k]}) begin
        hdr_fix[k]  = ~hdr_raw[k];
        syn_col_hit = 1'b1;
      end
    end

    // A lone syndrome bit means the received parity bit itself was hit.
    syn_par_hit = (syndrome != 6'd0) && ((syndrome & (syndrome - 6'd1)) == 6'd0);
    hdr_corr    = syn_col_hit | syn_par_hit;
    hdr_ok      = (syndrome == 6'd0) | hdr_corr;
  end

  assign hdr_dt = hdr_fix[5:0];
  assign hdr_vc = hdr_fix[7:6];
  assign hdr_wc = hdr_fix[23:8];
  assign vc_ok  = VC_ACCEPT[hdr_vc];

  // ---------------------------------------------------------------------------
  // Packet state machine with registered outputs
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [16:0] remain_q, remain_d;
  logic        payload_valid_q, payload_valid_d;
  logic [31:0] payload_q, payload_d;
  logic [3:0]  payload_be_q, payload_be_d;
  logic        payload_last_q, payload_last_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic        line_start_q, line_start_d;
  logic        line_end_q, line_end_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] wc_q, wc_d;
  logic        ecc_corrected_q, ecc_corrected_d;
  logic        ecc_error_q, ecc_error_d;
  logic        truncated_q, truncated_d;
  logic [3:0]  last_be;

  always_comb begin
    case (remain_q[2:0])
      3'd1:    last_be = 4'b0001;
      3'd2:    last_be = 4'b0011;
      3'd3:    last_be = 4'b0111;
      default: last_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    remain_d        = remain_q;
    payload_valid_d = 1'b0;
    payload_d       = payload_q;
    payload_be_d    = payload_be_q;
    payload_last_d  = 1'b0;
    frame_start_d   = 1'b0;
    frame_end_d     = 1'b0;
    line_start_d    = 1'b0;
    line_end_d      = 1'b0;
    vc_d            = vc_q;
    dt_d            = dt_q;
    wc_d            = wc_q;
    ecc_corrected_d = 1'b0;
    ecc_error_d     = 1'b0;
    truncated_d     = 1'b0;

    unique case (state_q)
      ST_SKIP: begin
        if (!data_valid_i) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (data_valid_i) begin
          state_d = ST_DRAIN;
          if (!hdr_ok) begin
            ecc_error_d = 1'b1;
          end else begin
            ecc_corrected_d = hdr_corr;
            if (vc_ok) begin
              vc_d = hdr_vc;
              dt_d = hdr_dt;
              wc_d = hdr_wc;
              if (hdr_dt < 6'h10) begin
                frame_start_d = (hdr_dt == 6'h00);
                frame_end_d   = (hdr_dt == 6'h01);
                line_start_d  = (hdr_dt == 6'h02);
                line_end_d    = (hdr_dt == 6'h03);
              end else if (hdr_wc != 16'd0) begin
                remain_d = {1'b0, hdr_wc};
                state_d  = ST_PAYLOAD;
              end
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (!data_valid_i) begin
          truncated_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          payload_valid_d = 1'b1;
          payload_d       = data_i;
          if (remain_q <= 17'd4) begin
            payload_be_d   = last_be;
            payload_last_d = 1'b1;
            state_d        = ST_DRAIN;
          end else begin
            payload_be_d = 4'b1111;
            remain_d     = remain_q - 17'd4;
          end
        end
      end

      ST_DRAIN: begin
        if (!data_valid_i) state_d = ST_IDLE;
      end

      default: state_d = ST_SKIP;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge value of every other flop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= ST_SKIP;
      remain_q        <= '0;
      payload_valid_q <= 1'b0;
      payload_q       <= '0;
      payload_be_q    <= '0;
      payload_last_q  <= 1'b0;
      frame_start_q   <= 1'b0;
      frame_end_q     <= 1'b0;
      line_start_q    <= 1'b0;
      line_end_q      <= 1'b0;
      vc_q            <= '0;
      dt_q            <= '0;
      wc_q            <= '0;
      ecc_corrected_q <= 1'b0;
      ecc_error_q     <= 1'b0;
      truncated_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      remain_q        <= remain_d;
      payload_valid_q <= payload_valid_d;
      payload_q       <= payload_d;
      payload_be_q    <= payload_be_d;
      payload_last_q  <= payload_last_d;
      frame_start_q   <= frame_start_d;
      frame_end_q     <= frame_end_d;
      line_start_q    <= line_start_d;
      line_end_q      <= line_end_d;
      vc_q            <= vc_d;
      dt_q            <= dt_d;
      wc_q            <= wc_d;
      ecc_corrected_q <= ecc_corrected_d;
      ecc_error_q     <= ecc_error_d;
      truncated_q     <= truncated_d;
    end
  end

  assign payload_valid_o = payload_valid_q;
  assign payload_o       = payload_q;
  assign payload_be_o    = payload_be_q;
  assign payload_last_o  = payload_last_q;
  assign frame_start_o   = frame_start_q;
  assign frame_end_o     = frame_end_q;
  assign line_start_o    = line_start_q;
  assign line_end_o      = line_end_q;
  assign vc_o            = vc_q;
  assign dt_o            = dt_q;
  assign word_count_o    = wc_q;
  assign ecc_corrected_o = ecc_corrected_q;
  assign ecc_error_o     = ecc_error_q;
  assign truncated_o     = truncated_q;

endmodule

// File: tb/tb_mipi_csi_header_parser.sv
// Self-checking bench for mipi_csi_header_parser: per-scenario tasks plus a payload scoreboard.
// Inputs change 1 time unit after the rising edge; payload is compared on the falling edge.
module tb_mipi_csi_header_parser;

  logic        clk_i;
  logic        reset_i;
  logic        data_valid_i;
  logic [31:0] data_i;
  logic        payload_valid_o;
  logic [31:0] payload_o;
  logic [3:0]  payload_be_o;
  logic        payload_last_o;
  logic        frame_start_o;
  logic        frame_end_o;
  logic        line_start_o;
  logic        line_end_o;
  logic [1:0]  vc_o;
  logic [5:0]  dt_o;
  logic [15:0] word_count_o;
  logic        ecc_corrected_o;
  logic        ecc_error_o;
  logic        truncated_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } exp_t;

  exp_t exp_q[$];

  mipi_csi_header_parser #(.VC_ACCEPT(4'b1111)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .data_valid_i    (data_valid_i),
    .data_i          (data_i),
    .payload_valid_o (payload_valid_o),
    .payload_o       (payload_o),
    .payload_be_o    (payload_be_o),
    .payload_last_o  (payload_last_o),
    .frame_start_o   (frame_start_o),
    .frame_end_o     (frame_end_o),
    .line_start_o    (line_start_o),
    .line_end_o      (line_end_o),
    .vc_o            (vc_o),
    .dt_o            (dt_o),
    .word_count_o    (word_count_o),
    .ecc_corrected_o (ecc_corrected_o),
    .ecc_error_o     (ecc_error_o),
    .truncated_o     (truncated_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference ECC written out bit by bit from the CSI-2 parity equations.
  function automatic logic [5:0] tb_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  function automatic logic [31:0] mk_hdr(input logic [1:0] vc, input logic [5:0] dt,
                                         input logic [15:0] wc);
    logic [23:0] d;
    d = {wc, vc, dt};
    return {2'b00, tb_ecc(d), d};
  endfunction

  // Wait for the next rising edge, then present one word; outputs now reflect the previous word.
  task automatic step(input logic v, input logic [31:0] d);
    @(posedge clk_i);
    #1;
    data_valid_i = v;
    data_i       = d;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] be, input logic last);
    exp_t e;
    e.data = d;
    e.be   = be;
    e.last = last;
    exp_q.push_back(e);
  endtask

  // Payload scoreboard.
  always @(negedge clk_i) begin
    if (payload_valid_o === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL payload_unexpected: got data %h be %b last %b, expected no payload",
                 payload_o, payload_be_o, payload_last_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({payload_o, payload_be_o, payload_last_o} !== {e.data, e.be, e.last}) begin
          n_fail++;
          $display("FAIL payload_word: got data %h be %b last %b, expected data %h be %b last %b",
                   payload_o, payload_be_o, payload_last_o, e.data, e.be, e.last);
        end
      end
    end
  end

  task automatic test_reset();
    reset_i      = 1'b1;
    data_valid_i = 1'b0;
    data_i       = '0;
    repeat (3) step(1'b0, 32'h0);
    n_checks++;
    if ({payload_valid_o, payload_last_o, payload_be_o, payload_o} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_payload: got v%b l%b be %b d %h, expected all zero",
               payload_valid_o, payload_last_o, payload_be_o, payload_o);
    end
    n_checks++;
    if ({frame_start_o, frame_end_o, line_start_o, line_end_o,
         ecc_corrected_o, ecc_error_o, truncated_o} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b, expected 0000000",
               {frame_start_o, frame_end_o, line_start_o, line_end_o,
                ecc_corrected_o, ecc_error_o, truncated_o});
    end
    n_checks++;
    if ({vc_o, dt_o, word_count_o} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_fields: got vc %h dt %h wc %h, expected 0", vc_o, dt_o, word_count_o);
    end
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    step(1'b0, 32'h0);
  endtask

  task automatic test_fs();
    step(1'b1, 32'h1A000100);
    step(1'b0, 32'h0);
    n_checks++;
    if (frame_start_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fs_pulse: got %b, expected 1", frame_start_o);
    end
    n_checks++;
    if ({vc_o, dt_o, word_count_o} !== {2'd0, 6'h00, 16'd1}) begin
      n_fail++;
      $display("FAIL fs_fields: got vc %h dt %h wc %h, expected 0 00 0001", vc_o, dt_o, word_count_o);
    end
    n_checks++;
    if ({ecc_corrected_o, ecc_error_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL fs_ecc_flags: got %b, expected 00", {ecc_corrected_o, ecc_error_o});
    end
    step(1'b0, 32'h0);
    n_checks++;
    if (frame_start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_one_cycle: got %b, expected 0", frame_start_o);
    end
  endtask

  task automatic test_short_types();
    for (int dt = 0; dt < 5; dt++) begin
      logic [3:0] exp_p;
      exp_p = (dt < 4) ? (4'b1000 >> dt) : 4'b0000;
      step(1'b1, mk_hdr(2'd2, 6'(dt), 16'h1234));
      step(1'b0, 32'h0);
      n_checks++;
      if ({frame_start_o, frame_end_o, line_start_o, line_end_o} !== exp_p) begin
        n_fail++;
        $display("FAIL short_pulse dt%0d: got %b, expected %b", dt,
                 {frame_start_o, frame_end_o, line_start_o, line_end_o}, exp_p);
      end
      n_checks++;
      if ({vc_o, dt_o} !== {2'd2, 6'(dt)}) begin
        n_fail++;
        $display("FAIL short_fields dt%0d: got vc %h dt %h, expected vc 2 dt %h", dt, vc_o, dt_o, dt);
      end
    end
  endtask

  task automatic test_raw10(input logic [31:0] hdr, input logic exp_corr);
    logic [31:0] w;
    step(1'b1, hdr);
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      push_exp(w, (i == 2) ? 4'b0011 : 4'b1111, i == 2);
      step(1'b1, w);
      if (i == 0) begin
        n_checks++;
        if ({dt_o, word_count_o, ecc_corrected_o, ecc_error_o} !== {6'h2B, 16'd10, exp_corr, 1'b0}) begin
          n_fail++;
          $display("FAIL raw10_hdr: got dt %h wc %0d corr %b err %b, expected dt 2b wc 10 corr %b err 0",
                   dt_o, word_count_o, ecc_corrected_o, ecc_error_o, exp_corr);
        end
      end
    end
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL raw10_drained: got %0d words outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_ecc_error();
    step(1'b1, 32'h2E000A28);
    step(1'b1, $urandom);
    n_checks++;
    if ({ecc_error_o, ecc_corrected_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL ecc_err_flags: got err %b corr %b, expected err 1 corr 0", ecc_error_o, ecc_corrected_o);
    end
    n_checks++;
    if ({dt_o, word_count_o} !== {6'h2B, 16'd10}) begin
      n_fail++;
      $display("FAIL ecc_err_fields: got dt %h wc %0d, expected dt 2b wc 10", dt_o, word_count_o);
    end
    step(1'b1, $urandom);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    test_fs();
  endtask

  task automatic test_truncate();
    logic [31:0] w;
    step(1'b1, mk_hdr(2'd0, 6'h2B, 16'd16));
    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      push_exp(w, 4'b1111, 1'b0);
      step(1'b1, w);
    end
    step(1'b0, 32'h0);
    // The next header arrives the cycle right after the parser falls back to IDLE.
    step(1'b1, 32'h1A000100);
    n_checks++;
    if ({truncated_o, payload_last_o, payload_valid_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL trunc_pulse: got trunc %b last %b valid %b, expected 1 0 0",
               truncated_o, payload_last_o, payload_valid_o);
    end
    step(1'b0, 32'h0);
    n_checks++;
    if ({frame_start_o, truncated_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL trunc_then_fs: got fs %b trunc %b, expected fs 1 trunc 0", frame_start_o, truncated_o);
    end
    // Valid drops exactly when the final word was due.
    step(1'b1, mk_hdr(2'd0, 6'h2B, 16'd8));
    w = $urandom;
    push_exp(w, 4'b1111, 1'b0);
    step(1'b1, w);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    n_checks++;
    if ({truncated_o, payload_last_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL trunc_at_last: got trunc %b last %b, expected 1 0", truncated_o, payload_last_o);
    end
  endtask

  task automatic test_last_be();
    int wc_tab[6] = '{1, 5, 6, 7, 8, 3};
    logic [31:0] w;
    for (int t = 0; t < 6; t++) begin
      int nw;
      nw = (wc_tab[t] + 3) / 4;
      step(1'b1, mk_hdr(2'd1, 6'h2B, 16'(wc_tab[t])));
      for (int i = 0; i < nw; i++) begin
        int r;
        r = wc_tab[t] - 4 * i;
        w = $urandom;
        push_exp(w, (i == nw - 1) ? 4'((1 << r) - 1) : 4'b1111, i == nw - 1);
        step(1'b1, w);
      end
      step(1'b1, $urandom);
      step(1'b0, 32'h0);
      n_checks++;
      if ({vc_o, word_count_o} !== {2'd1, 16'(wc_tab[t])}) begin
        n_fail++;
        $display("FAIL last_be_fields wc%0d: got vc %h wc %0d, expected vc 1", wc_tab[t], vc_o, word_count_o);
      end
    end
    // A zero-length long packet carries no payload.
    step(1'b1, mk_hdr(2'd0, 6'h2B, 16'd0));
    step(1'b1, $urandom);
    step(1'b0, 32'h0);
    n_checks++;
    if (word_count_o !== 16'd0) begin
      n_fail++;
      $display("FAIL wc_zero: got wc %0d, expected 0", word_count_o);
    end
  endtask

  task automatic test_reset_mid_payload();
    logic [31:0] w;
    step(1'b1, mk_hdr(2'd0, 6'h2B, 16'd16));
    w = $urandom;
    push_exp(w, 4'b1111, 1'b0);
    step(1'b1, w);
    @(posedge clk_i);
    #1;
    reset_i      = 1'b1;
    data_valid_i = 1'b1;
    data_i       = $urandom;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    data_i  = $urandom;
    n_checks++;
    if ({payload_valid_o, payload_be_o, payload_o, dt_o, word_count_o, truncated_o} !== 60'd0) begin
      n_fail++;
      $display("FAIL reset_mid_payload: got v%b be %b d %h dt %h wc %h trunc %b, expected all zero",
               payload_valid_o, payload_be_o, payload_o, dt_o, word_count_o, truncated_o);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom);
      n_checks++;
      if ({truncated_o, frame_start_o, ecc_error_o} !== 3'b000) begin
        n_fail++;
        $display("FAIL skip_quiet: got trunc %b fs %b err %b, expected 000",
                 truncated_o, frame_start_o, ecc_error_o);
      end
    end
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    test_fs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fs();
    test_short_types();
    test_raw10(32'h2E000A2B, 1'b0);
    test_raw10(32'h2E000A29, 1'b1);
    test_ecc_error();
    test_truncate();
    test_last_be();
    test_reset_mid_payload();
    repeat (3) step(1'b0, 32'h0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d words outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
